// File: rtl/hdd_sd_if.sv
// hdd_sd_if: hps_io virtual-disk handshake for one slot.
// The request side (master) drives the LBA and the read/write strobes.
// The hps_io side (slave) answers with sd_ack.
interface hdd_sd_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
  modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

// File: rtl/hdd_sd_req.sv
// hdd_sd_req: request sequencer between the Apple II HDD controller and the
// hps_io virtual-disk port (slot 1), clk_sys domain.
//
// The block takes single-cycle read/write pulses into an active slot and holds
// one further request in a pending slot. It drives the sd_rd/sd_wr/sd_ack
// handshake and holds cpu_wait high while a block is in flight. It also tracks
// the mount and write-protect state and rejects requests that cannot be served.
//
// Optional feature: define HDD_TIMEOUT_EN to abort a request that sees no
// sd_ack rise within TIMEOUT_CYCLES cycles in REQ. Without the macro, REQ
// waits indefinitely and no counter exists.
module hdd_sd_req #(
  parameter int                   TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd14000000
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            soft_reset,
  input  logic            hdd_read,
  input  logic            hdd_write,
  input  logic [31:0]     hdd_lba,
  input  logic            img_mounted,
  input  logic            img_readonly,
  input  logic [63:0]     img_size,
  hdd_sd_if.master        sd,
  output logic            cpu_wait,
  output logic            hdd_mounted,
  output logic            hdd_protect,
  output logic            err_pulse,
  output logic [1:0]      err_code
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_REJECT  = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  state_t      state;

  // ack edge detection: ack_q is the registered ack, edges are registered once more
  logic        ack_q;
  logic        ack_rise_p1;
  logic        ack_fall_p1;

  // pending slot
  logic        pend_vld;
  logic        pend_wr;
  logic [31:0] pend_lba;

  // capture decode
  logic        take_wr;
  logic        take_rd;
  logic        both_drop;
  logic        req_vld;
  logic        req_rej;
  logic        req_ok;
  logic        start_new;
  logic        launch_pend;
  logic        to_pend;
  logic        overrun_drop;
  logic        tmo_hit;
  logic        err_any;
  logic [1:0]  err_next;

  // Register sd_ack, then register its rise/fall edges for the FSM
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ack_q       <= 1'b0;
      ack_rise_p1 <= 1'b0;
      ack_fall_p1 <= 1'b0;
    end else if (soft_reset) begin
      ack_q       <= 1'b0;
      ack_rise_p1 <= 1'b0;
      ack_fall_p1 <= 1'b0;
    end else begin
      ack_q       <= sd.sd_ack;
      ack_rise_p1 <= sd.sd_ack & ~ack_q;
      ack_fall_p1 <= ~sd.sd_ack & ack_q;
    end
  end

`ifdef HDD_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;

  // Count cycles spent in REQ; held at zero elsewhere so every REQ entry starts from 0
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (soft_reset || (state != REQ)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // A same-cycle ack rise wins over the timeout
  assign tmo_hit = (state == REQ) && !ack_rise_p1 && (tmo_cnt == TIMEOUT_CYCLES);
`else
  assign tmo_hit = 1'b0;
  wire unused_tmo = &{1'b0, TIMEOUT_CYCLES};
`endif

  // Decode incoming pulses into slot moves and error causes
  always_comb begin
    take_wr      = hdd_write;
    take_rd      = hdd_read & ~hdd_write;
    both_drop    = hdd_read & hdd_write;
    req_vld      = take_wr | take_rd;
    req_rej      = req_vld & (~hdd_mounted | (take_wr & hdd_protect));
    req_ok       = req_vld & ~req_rej;
    // DONE hands the pending request straight to REQ, freeing the slot this cycle
    launch_pend  = pend_vld & (state == DONE);
    // With nothing pending, a request seen in DONE is started at once so cpu_wait never dips
    start_new    = req_ok & ~pend_vld & ((state == IDLE) | (state == DONE));
    to_pend      = req_ok & ~start_new & (~pend_vld | launch_pend);
    overrun_drop = req_ok & ~start_new & pend_vld & ~launch_pend;
    err_any      = req_rej | both_drop | overrun_drop | tmo_hit;
    err_next     = ERR_NONE;
    if (req_rej)                   err_next = ERR_REJECT;
    if (both_drop || overrun_drop) err_next = ERR_OVERRUN;
    if (tmo_hit)                   err_next = ERR_TIMEOUT;
  end

  // Pending request payload; only meaningful while pend_vld is set
  always_ff @(posedge clk_sys) begin
    if (to_pend) begin
      pend_wr  <= take_wr;
      pend_lba <= hdd_lba;
    end
  end

  // Request FSM with registered handshake, stall and error outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sd.sd_lba <= '0;
      sd.sd_rd  <= 1'b0;
      sd.sd_wr  <= 1'b0;
      cpu_wait  <= 1'b0;
      pend_vld  <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (soft_reset) begin
      state     <= IDLE;
      sd.sd_lba <= '0;
      sd.sd_rd  <= 1'b0;
      sd.sd_wr  <= 1'b0;
      cpu_wait  <= 1'b0;
      pend_vld  <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      err_pulse <= err_any;
      if (err_any) begin
        err_code <= err_next;
      end

      if (to_pend) begin
        pend_vld <= 1'b1;
      end else if (launch_pend) begin
        pend_vld <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_new) begin
            state     <= REQ;
            sd.sd_lba <= hdd_lba;
            sd.sd_rd  <= take_rd;
            sd.sd_wr  <= take_wr;
            cpu_wait  <= 1'b1;
          end
        end
        REQ: begin
          if (ack_rise_p1) begin
            state    <= XFER;
            sd.sd_rd <= 1'b0;
            sd.sd_wr <= 1'b0;
          end else if (tmo_hit) begin
            state    <= DONE;
            sd.sd_rd <= 1'b0;
            sd.sd_wr <= 1'b0;
          end
        end
        XFER: begin
          if (ack_fall_p1) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (launch_pend) begin
            state     <= REQ;
            sd.sd_lba <= pend_lba;
            sd.sd_rd  <= ~pend_wr;
            sd.sd_wr  <= pend_wr;
          end else if (start_new) begin
            state     <= REQ;
            sd.sd_lba <= hdd_lba;
            sd.sd_rd  <= take_rd;
            sd.sd_wr  <= take_wr;
          end else begin
            state    <= IDLE;
            cpu_wait <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Mount/write-protect tracking; survives soft_reset and never aborts a transfer
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hdd_mounted <= 1'b0;
      hdd_protect <= 1'b0;
    end else if (img_mounted) begin
      hdd_mounted <= (img_size != 64'd0);
      hdd_protect <= img_readonly;
    end
  end

endmodule

// File: tb/tb_hdd_sd_req.sv
// tb_hdd_sd_req: directed self-checking bench for hdd_sd_req.
module tb_hdd_sd_req;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        soft_reset = 1'b0;
  logic        hdd_read = 1'b0;
  logic        hdd_write = 1'b0;
  logic [31:0] hdd_lba = 32'd0;
  logic        img_mounted = 1'b0;
  logic        img_readonly = 1'b0;
  logic [63:0] img_size = 64'd0;
  logic        cpu_wait;
  logic        hdd_mounted;
  logic        hdd_protect;
  logic        err_pulse;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  hdd_sd_if sd ();

  hdd_sd_req #(.TIMEOUT_W(24), .TIMEOUT_CYCLES(24'd100)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .soft_reset  (soft_reset),
    .hdd_read    (hdd_read),
    .hdd_write   (hdd_write),
    .hdd_lba     (hdd_lba),
    .img_mounted (img_mounted),
    .img_readonly(img_readonly),
    .img_size    (img_size),
    .sd          (sd),
    .cpu_wait    (cpu_wait),
    .hdd_mounted (hdd_mounted),
    .hdd_protect (hdd_protect),
    .err_pulse   (err_pulse),
    .err_code    (err_code)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic do_mount(input logic [63:0] size, input logic ro);
    img_size = size; img_readonly = ro; img_mounted = 1'b1;
    step();
    img_mounted = 1'b0;
  endtask

  task automatic soft_clr();
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
  endtask

  task automatic pulse(input logic rd, input logic wr, input logic [31:0] lba);
    hdd_read = rd; hdd_write = wr; hdd_lba = lba;
    step();
    hdd_read = 1'b0; hdd_write = 1'b0;
  endtask

  // From REQ: ack high 4 cycles, then wait until the FSM is back in IDLE
  task automatic finish_xfer();
    sd.sd_ack = 1'b1;
    step(4);
    sd.sd_ack = 1'b0;
    step(3);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(2);
    checks++; if (sd.sd_rd !== 1'b0) begin errors++; $display("FAIL reset_sd_rd: got %b want 0", sd.sd_rd); end
    checks++; if (sd.sd_wr !== 1'b0) begin errors++; $display("FAIL reset_sd_wr: got %b want 0", sd.sd_wr); end
    checks++; if (sd.sd_lba !== 32'd0) begin errors++; $display("FAIL reset_sd_lba: got %h want 0", sd.sd_lba); end
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL reset_cpu_wait: got %b want 0", cpu_wait); end
    checks++; if (hdd_mounted !== 1'b0) begin errors++; $display("FAIL reset_mounted: got %b want 0", hdd_mounted); end
    checks++; if (hdd_protect !== 1'b0) begin errors++; $display("FAIL reset_protect: got %b want 0", hdd_protect); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_unmounted_reject();
    pulse(1'b1, 1'b0, 32'h1);
    checks++; if (sd.sd_rd !== 1'b0) begin errors++; $display("FAIL unmnt_sd_rd: got %b want 0", sd.sd_rd); end
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL unmnt_cpu_wait: got %b want 0", cpu_wait); end
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL unmnt_err_pulse: got %b want 1", err_pulse); end
    checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL unmnt_err_code: got %0d want 1", err_code); end
    step();
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL unmnt_pulse_len: got %b want 0", err_pulse); end
  endtask

  task automatic test_read();
    do_mount(64'd1000, 1'b0);
    checks++; if (hdd_mounted !== 1'b1) begin errors++; $display("FAIL mount_rw: got %b want 1", hdd_mounted); end
    checks++; if (hdd_protect !== 1'b0) begin errors++; $display("FAIL mount_rw_prot: got %b want 0", hdd_protect); end
    soft_clr();
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL soft_clr_err: got %0d want 0", err_code); end
    checks++; if (hdd_mounted !== 1'b1) begin errors++; $display("FAIL soft_keeps_mount: got %b want 1", hdd_mounted); end
    pulse(1'b1, 1'b0, 32'h12);
    checks++; if (sd.sd_rd !== 1'b1) begin errors++; $display("FAIL read_sd_rd: got %b want 1", sd.sd_rd); end
    checks++; if (sd.sd_wr !== 1'b0) begin errors++; $display("FAIL read_sd_wr: got %b want 0", sd.sd_wr); end
    checks++; if (sd.sd_lba !== 32'h12) begin errors++; $display("FAIL read_lba: got %h want 12", sd.sd_lba); end
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL read_cpu_wait: got %b want 1", cpu_wait); end
    sd.sd_ack = 1'b1;
    step();
    checks++; if (sd.sd_rd !== 1'b1) begin errors++; $display("FAIL read_rd_a1: got %b want 1", sd.sd_rd); end
    step();
    checks++; if (sd.sd_rd !== 1'b0) begin errors++; $display("FAIL read_rd_a2: got %b want 0", sd.sd_rd); end
    step(2);
    sd.sd_ack = 1'b0;
    step(2);
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL read_wait_f2: got %b want 1", cpu_wait); end
    step();
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL read_wait_f3: got %b want 0", cpu_wait); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL read_err_code: got %0d want 0", err_code); end
  endtask

  task automatic test_protect();
    do_mount(64'd1000, 1'b1);
    checks++; if (hdd_protect !== 1'b1) begin errors++; $display("FAIL mount_ro: got %b want 1", hdd_protect); end
    pulse(1'b0, 1'b1, 32'h5);
    checks++; if (sd.sd_wr !== 1'b0) begin errors++; $display("FAIL prot_sd_wr: got %b want 0", sd.sd_wr); end
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL prot_cpu_wait: got %b want 0", cpu_wait); end
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL prot_err_pulse: got %b want 1", err_pulse); end
    checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL prot_err_code: got %0d want 1", err_code); end
    step();
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL prot_pulse_len: got %b want 0", err_pulse); end
    checks++; if (sd.sd_wr !== 1'b0) begin errors++; $display("FAIL prot_sd_wr2: got %b want 0", sd.sd_wr); end
    pulse(1'b1, 1'b0, 32'h7);
    checks++; if (sd.sd_rd !== 1'b1) begin errors++; $display("FAIL prot_read_ok: got %b want 1", sd.sd_rd); end
    checks++; if (sd.sd_lba !== 32'h7) begin errors++; $display("FAIL prot_read_lba: got %h want 7", sd.sd_lba); end
    finish_xfer();
    do_mount(64'd1000, 1'b0);
    soft_clr();
  endtask

  task automatic test_back_to_back();
    pulse(1'b1, 1'b0, 32'h3);
    sd.sd_ack = 1'b1;
    step(2);
    pulse(1'b0, 1'b1, 32'h5);
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL b2b_pend_ok: got %b want 0", err_pulse); end
    pulse(1'b1, 1'b0, 32'h6);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL b2b_ovr_pulse: got %b want 1", err_pulse); end
    checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL b2b_ovr_code: got %0d want 2", err_code); end
    sd.sd_ack = 1'b0;
    step(2);
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL b2b_wait_f2: got %b want 1", cpu_wait); end
    checks++; if (sd.sd_wr !== 1'b0) begin errors++; $display("FAIL b2b_wr_f2: got %b want 0", sd.sd_wr); end
    step();
    checks++; if (sd.sd_wr !== 1'b1) begin errors++; $display("FAIL b2b_wr_f3: got %b want 1", sd.sd_wr); end
    checks++; if (sd.sd_rd !== 1'b0) begin errors++; $display("FAIL b2b_rd_f3: got %b want 0", sd.sd_rd); end
    checks++; if (sd.sd_lba !== 32'h5) begin errors++; $display("FAIL b2b_lba_f3: got %h want 5", sd.sd_lba); end
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL b2b_wait_f3: got %b want 1", cpu_wait); end
    finish_xfer();
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL b2b_wait_end: got %b want 0", cpu_wait); end
    step(3);
    checks++; if (sd.sd_rd !== 1'b0) begin errors++; $display("FAIL b2b_read_dropped: got %b want 0", sd.sd_rd); end
  endtask

  task automatic test_simultaneous();
    soft_clr();
    pulse(1'b1, 1'b1, 32'h9);
    checks++; if (sd.sd_wr !== 1'b1) begin errors++; $display("FAIL simul_sd_wr: got %b want 1", sd.sd_wr); end
    checks++; if (sd.sd_rd !== 1'b0) begin errors++; $display("FAIL simul_sd_rd: got %b want 0", sd.sd_rd); end
    checks++; if (sd.sd_lba !== 32'h9) begin errors++; $display("FAIL simul_lba: got %h want 9", sd.sd_lba); end
    checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL simul_err_code: got %0d want 2", err_code); end
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL simul_err_pulse: got %b want 1", err_pulse); end
    finish_xfer();
    step(2);
    checks++; if (sd.sd_rd !== 1'b0) begin errors++; $display("FAIL simul_no_read: got %b want 0", sd.sd_rd); end
  endtask

  task automatic test_soft_reset();
    soft_clr();
    pulse(1'b1, 1'b0, 32'h20);
    sd.sd_ack = 1'b1;
    step(2);
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL sr_xfer_wait: got %b want 1", cpu_wait); end
    soft_clr();
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL sr_cpu_wait: got %b want 0", cpu_wait); end
    checks++; if (sd.sd_rd !== 1'b0) begin errors++; $display("FAIL sr_sd_rd: got %b want 0", sd.sd_rd); end
    checks++; if (hdd_mounted !== 1'b1) begin errors++; $display("FAIL sr_mounted: got %b want 1", hdd_mounted); end
    sd.sd_ack = 1'b0;
    step(4);
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL sr_late_ack_wait: got %b want 0", cpu_wait); end
    checks++; if ((sd.sd_rd | sd.sd_wr) !== 1'b0) begin errors++; $display("FAIL sr_late_ack_req: got %b want 0", sd.sd_rd | sd.sd_wr); end
    // soft reset in REQ with a request waiting in the pending slot
    pulse(1'b1, 1'b0, 32'h1);
    pulse(1'b1, 1'b0, 32'h2);
    checks++; if (sd.sd_lba !== 32'h1) begin errors++; $display("FAIL sr_req_lba: got %h want 1", sd.sd_lba); end
    soft_clr();
    checks++; if (sd.sd_rd !== 1'b0) begin errors++; $display("FAIL sr_req_rd: got %b want 0", sd.sd_rd); end
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL sr_req_wait: got %b want 0", cpu_wait); end
    step(3);
    checks++; if (sd.sd_rd !== 1'b0) begin errors++; $display("FAIL sr_pend_cleared: got %b want 0", sd.sd_rd); end
    pulse(1'b1, 1'b0, 32'h4);
    checks++; if (sd.sd_lba !== 32'h4) begin errors++; $display("FAIL sr_after_lba: got %h want 4", sd.sd_lba); end
    finish_xfer();
  endtask

  task automatic test_async_reset();
    pulse(1'b1, 1'b0, 32'h30);
    checks++; if (sd.sd_rd !== 1'b1) begin errors++; $display("FAIL ar_pre_rd: got %b want 1", sd.sd_rd); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (sd.sd_rd !== 1'b0) begin errors++; $display("FAIL ar_sd_rd: got %b want 0", sd.sd_rd); end
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL ar_cpu_wait: got %b want 0", cpu_wait); end
    checks++; if (hdd_mounted !== 1'b0) begin errors++; $display("FAIL ar_mounted: got %b want 0", hdd_mounted); end
    step();
    reset_n = 1'b1;
    step();
    pulse(1'b1, 1'b0, 32'h31);
    checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL ar_unmnt_reject: got %0d want 1", err_code); end
  endtask

`ifdef HDD_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    do_mount(64'd1000, 1'b0);
    soft_clr();
    pulse(1'b1, 1'b0, 32'h40);
    k = 0;
    while (sd.sd_rd === 1'b1 && k < 300) begin
      step();
      k++;
    end
    checks++; if (k !== 101) begin errors++; $display("FAIL tmo_cycles: got %0d want 101", k); end
    checks++; if (err_code !== 2'd3) begin errors++; $display("FAIL tmo_err_code: got %0d want 3", err_code); end
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL tmo_err_pulse: got %b want 1", err_pulse); end
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL tmo_wait_done: got %b want 1", cpu_wait); end
    step();
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL tmo_wait_rel: got %b want 0", cpu_wait); end
  endtask
`endif

  initial begin
    sd.sd_ack = 1'b0;
    test_reset();
    test_unmounted_reject();
    test_read();
    test_protect();
    test_back_to_back();
    test_simultaneous();
    test_soft_reset();
    test_async_reset();
`ifdef HDD_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
